aes_sbox_pipe: RTL and testbench

Multi-lane, pipelined AES byte-substitution unit. It applies either the forward S-box (SubBytes) or the inverse S-box (InvSubBytes) to NUM_LANES bytes per transaction, with the direction selected per transaction. It replaces the single-byte combinational inverse S-box in the datapath. It sits between the round-key/state mux and the ShiftRows/MixColumns stage and provides valid/ready flow control in both directions.

---
 rtl/aes_sbox_pipe.sv | 147 ++++++++++++++
 tb/tb_aes_sbox_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_pipe.sv
// ---------------------------------------------------------------------------
// aes_sbox_pipe
//
// Multi-lane, two-stage pipelined AES byte substitution. Each transaction
// carries NUM_LANES bytes and one direction bit. The direction bit selects
// the forward S-box (SubBytes) or the inverse S-box (InvSubBytes) for every
// lane of that transaction. The S-box is computed rather than looked up:
//   forward : S(x)    = affine(inv(x))
//   inverse : S^-1(x) = inv(affine^-1(x))
// Both directions share one GF(2^8) inverter per lane.
//
// Stage S1 registers the input bytes. When inv=1, the affine^-1 pre-transform
// is already applied to those bytes. Stage S2 registers the final bytes,
// which are inv(S1), plus the forward affine when inv=0. The GF inverter
// therefore sits between S1 and S2.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   in_valid   in   input transaction valid
//   in_ready   out  unit accepts an input transaction this cycle
//   in_inv     in   0 = forward S-box, 1 = inverse S-box
//   in_data    in   NUM_LANES input bytes, lane k at [8k+7:8k]
//   out_valid  out  output transaction valid
//   out_ready  in   downstream accepts the output this cycle
//   out_inv    out  direction bit that travelled with the transaction
//   out_data   out  substituted bytes, same lane order as the input
//   xfer_cnt   out  wrapping count of completed output transfers
// ---------------------------------------------------------------------------
module aes_sbox_pipe #(
  parameter int NUM_LANES = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inv,
  input  logic [8*NUM_LANES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_inv,
  output logic [8*NUM_LANES-1:0] out_data,
  output logic [CNT_WIDTH-1:0]   xfer_cnt
);

  localparam int DW = 8 * NUM_LANES;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254, using the product x^2 * x^4 * ... * x^128.
  // x=0 yields 0 without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] dbl;
    dbl = {x, x} << n;
    return dbl[15:8];
  endfunction

  // Forward affine: b_i = x_i ^ x_{i+4} ^ x_{i+5} ^ x_{i+6} ^ x_{i+7} ^ c_i, with c = 0x63.
  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  // Inverse affine: b_i = x_{i+2} ^ x_{i+5} ^ x_{i+7} ^ d_i, with d = 0x05.
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
  endfunction

  logic          s1_v_q, s2_v_q;
  logic          s1_inv_q, s2_inv_q;
  logic [DW-1:0] s1_data_q, s2_data_q;
  logic [DW-1:0] s1_data_d, s2_data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic          s1_adv, s2_adv;
  logic          out_xfer;

  // A stage may load when it is empty or its contents are moving on.
  // A stall in S2 therefore reaches the input in the same cycle.
  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_xfer = s2_v_q && out_ready;
  assign cnt_d    = cnt_q + CNT_WIDTH'(1);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] inv_b;
    // Input -> S1: the inverse direction applies affine^-1 before the inverter.
    assign s1_data_d[8*g +: 8] = in_inv ? inv_affine(in_data[8*g +: 8]) : in_data[8*g +: 8];
    // S1 -> S2: shared inverter, then the forward direction applies the affine.
    assign inv_b               = gf_inv(s1_data_q[8*g +: 8]);
    assign s2_data_d[8*g +: 8] = s1_inv_q ? inv_b : fwd_affine(inv_b);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_inv_q  <= 1'b0;
      s2_inv_q  <= 1'b0;
      s1_data_q <= '0;
      s2_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (s2_adv) begin
        s2_v_q    <= s1_v_q;
        s2_inv_q  <= s1_inv_q;
        s2_data_q <= s2_data_d;
      end
      // A cycle without in_valid loads a bubble; the next cycle overwrites it.
      if (s1_adv) begin
        s1_v_q    <= in_valid;
        s1_inv_q  <= in_inv;
        s1_data_q <= s1_data_d;
      end
      if (out_xfer) cnt_q <= cnt_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_inv   = s2_inv_q;
  assign out_data  = s2_data_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// ---------------------------------------------------------------------------
// tb_aes_sbox_pipe
//
// Directed and randomised stimulus for aes_sbox_pipe. There are two
// instances: a main one with a 16-bit counter and a second one with a 4-bit
// counter. Both share the same inputs. The reference S-box comes from the
// generator-3 log/antilog walk of GF(2^8). The inverse S-box is obtained by
// inverting the forward table.
// ---------------------------------------------------------------------------
module tb_aes_sbox_pipe;
  localparam int NL = 4;
  localparam int DW = 8 * NL;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_inv;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready, out_valid, out_inv;
  logic [DW-1:0] out_data;
  logic [15:0]   xfer_cnt;

  logic          w_in_ready, w_out_valid, w_out_inv;
  logic [DW-1:0] w_out_data;
  logic [3:0]    w_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  typedef struct {
    logic [DW-1:0] d;
    logic          inv;
  } txn_t;
  txn_t exp_q[$];
  int unsigned model_cnt;

  aes_sbox_pipe #(.NUM_LANES(NL), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_inv(out_inv), .out_data(out_data),
    .xfer_cnt(xfer_cnt)
  );

  aes_sbox_pipe #(.NUM_LANES(NL), .CNT_WIDTH(4)) u_wrap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_inv(in_inv), .in_data(in_data), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_inv(w_out_inv), .out_data(w_out_data),
    .xfer_cnt(w_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    for (int i = 0; i < NL; i++)
      r[8*i +: 8] = inv ? isbox[d[8*i +: 8]] : sbox[d[8*i +: 8]];
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  // Scoreboard: sampled on the falling edge, describing the coming rising edge.
  initial begin
    txn_t          t;
    txn_t          nt;
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    logic          prev_inv;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_inv   = 1'b0;
    model_cnt  = 0;
    forever begin
      @(negedge clk);
      chk("xfer_cnt", {48'h0, xfer_cnt}, {48'h0, model_cnt[15:0]});
      chk("wrap_cnt", {60'h0, w_cnt}, {60'h0, model_cnt[3:0]});
      if (prev_stall) begin
        chk("hold_valid", {63'h0, out_valid}, 64'h1);
        chk("hold_data", {32'h0, out_data}, {32'h0, prev_d});
        chk("hold_inv", {63'h0, out_inv}, {63'h0, prev_inv});
      end
      if (!reset_n) begin
        exp_q.delete();
        model_cnt  = 0;
        prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stale_output actual=%0h required=none", out_data);
          end else begin
            t = exp_q.pop_front();
            chk("out_data", {32'h0, out_data}, {32'h0, t.d});
            chk("out_inv", {63'h0, out_inv}, {63'h0, t.inv});
          end
          model_cnt++;
        end
        if (in_valid && in_ready) begin
          nt.d   = model(in_data, in_inv);
          nt.inv = in_inv;
          exp_q.push_back(nt);
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_inv   = out_inv;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic inv);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=in_ready0 required=in_ready1");
        break;
      end
    end
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) cyc();
    chk("drain_empty", 64'(exp_q.size()), 64'h0);
    chk("drain_valid", {63'h0, out_valid}, 64'h0);
  endtask

  initial begin
    int acc;
    int sent;
    int n;
    build_tables();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Pin the reference tables to known FIPS-197 entries.
    chk("S00", {56'h0, sbox[8'h00]}, 64'h63);
    chk("S01", {56'h0, sbox[8'h01]}, 64'h7C);
    chk("S53", {56'h0, sbox[8'h53]}, 64'hED);
    chk("SFF", {56'h0, sbox[8'hFF]}, 64'h16);
    chk("Si00", {56'h0, isbox[8'h00]}, 64'h52);
    chk("Si63", {56'h0, isbox[8'h63]}, 64'h00);
    chk("Si7C", {56'h0, isbox[8'h7C]}, 64'h01);
    chk("SiFF", {56'h0, isbox[8'hFF]}, 64'h7D);

    // Reset state.
    repeat (2) cyc();
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_data", {32'h0, out_data}, 64'h0);
    chk("rst_out_inv", {63'h0, out_inv}, 64'h0);
    chk("rst_cnt", {48'h0, xfer_cnt}, 64'h0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);

    // Mixed direction, back to back.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {4{8'h53}};
    in_inv    = 1'b0;
    cyc();
    in_data = {4{8'hED}};
    in_inv  = 1'b1;
    chk("mix_not_early", {63'h0, out_valid}, 64'h0);
    cyc();
    in_valid = 1'b0;
    chk("mix0_valid", {63'h0, out_valid}, 64'h1);
    chk("mix0_data", {32'h0, out_data}, {32'h0, {4{8'hED}}});
    chk("mix0_inv", {63'h0, out_inv}, 64'h0);
    cyc();
    chk("mix1_valid", {63'h0, out_valid}, 64'h1);
    chk("mix1_data", {32'h0, out_data}, {32'h0, {4{8'h53}}});
    chk("mix1_inv", {63'h0, out_inv}, 64'h1);
    drain();

    // Forward sweep, then inverse sweep, over all 256 byte values.
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 64; t++)
      send({8'(4*t+3), 8'(4*t+2), 8'(4*t+1), 8'(4*t)}, 1'b0);
    drain();
    chk("fwd_cnt", {48'h0, xfer_cnt}, 64'd64);
    for (int t = 0; t < 64; t++)
      send({8'(4*t+3), 8'(4*t+2), 8'(4*t+1), 8'(4*t)}, 1'b1);
    drain();
    chk("inv_cnt", {48'h0, xfer_cnt}, 64'd128);

    // Backpressure: the pipeline holds exactly two transactions.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      in_data = {4{8'(8'hA0 + k)}};
      @(negedge clk);
      if (in_ready) acc++;
      cyc();
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {63'h0, in_ready}, 64'h1);
    chk("bp_release_valid", {63'h0, out_valid}, 64'h1);
    cyc();
    out_ready = 1'b0;
    chk("bp_one_xfer", {48'h0, xfer_cnt}, 64'd1);
    #1;
    chk("bp_full_again", {63'h0, in_ready}, 64'h0);
    drain();

    // Random backpressure and input gaps over 1000 transactions.
    sent = 0;
    n = 0;
    while (sent < 1000 && n < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_inv    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      cyc();
      n++;
    end
    in_valid = 1'b0;
    chk("rand_sent", 64'(sent), 64'd1000);
    drain();

    // Reset while the pipeline is full, with a transfer pending on both sides.
    out_ready = 1'b0;
    send({4{8'h11}}, 1'b0);
    send({4{8'h22}}, 1'b1);
    in_valid  = 1'b1;
    in_data   = {4{8'h33}};
    out_ready = 1'b1;
    reset_n   = 1'b0;
    cyc();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_rst_data", {32'h0, out_data}, 64'h0);
    chk("mid_rst_inv", {63'h0, out_inv}, 64'h0);
    chk("mid_rst_cnt", {48'h0, xfer_cnt}, 64'h0);
    chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
    repeat (5) cyc();
    chk("mid_rst_no_stale", {63'h0, out_valid}, 64'h0);

    // Counter wrap on the 4-bit instance.
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 17; t++) send({4{8'(t)}}, 1'b0);
    drain();
    chk("wrap_17", {60'h0, w_cnt}, 64'd1);
    chk("main_17", {48'h0, xfer_cnt}, 64'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
